// File: rtl/rvsteel_spi.sv
// rtl/rvsteel_spi.sv - memory-mapped 8-bit SPI manager for the rvsteel bus
module rvsteel_spi #(
    parameter int NUM_CS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        rw_address,
    output logic [31:0]       read_data,
    input  logic              read_request,
    output logic              read_response,
    input  logic [31:0]       write_data,
    input  logic [3:0]        write_strobe,
    input  logic              write_request,
    output logic              write_response,
    output logic              sclk,
    output logic              pico,
    input  logic              poci,
    output logic [NUM_CS-1:0] cs
);
    localparam logic [2:0] REG_CPOL   = 3'd0;
    localparam logic [2:0] REG_CPHA   = 3'd1;
    localparam logic [2:0] REG_CS     = 3'd2;
    localparam logic [2:0] REG_DIV    = 3'd3;
    localparam logic [2:0] REG_WDATA  = 3'd4;
    localparam logic [2:0] REG_RDATA  = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;

    // LEAD is the half-period that ends with the leading sclk edge,
    // TRAIL the half-period that ends with the trailing edge.
    typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;

    state_t            state_q, state_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [NUM_CS-1:0] cs_q, cs_d;
    logic [7:0]        div_q, div_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        hp_cnt_q, hp_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        rx_q, rx_d;
    logic              sclk_q, sclk_d;
    logic              pico_q, pico_d;
    logic              poci_s1_q, poci_s1_d;
    logic              poci_s2_q, poci_s2_d;
    logic              read_response_q, read_response_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              write_response_q, write_response_d;

    logic              busy;
    logic              wr_en;
    logic              half_done;
    logic [31:0]       cs_ext;
    logic [31:0]       reg_rdata;

    assign busy      = (state_q != IDLE);
    assign wr_en     = write_request & write_strobe[0];
    assign half_done = (hp_cnt_q == div_q);
    assign poci_s1_d = poci;
    assign poci_s2_d = poci_s1_q;

    assign read_data      = read_data_q;
    assign read_response  = read_response_q;
    assign write_response = write_response_q;
    assign sclk           = sclk_q;
    assign pico           = pico_q;
    assign cs             = cs_q;

    // Register read mux; unmapped and write-only offsets read as zero
    always_comb begin
        cs_ext              = '0;
        cs_ext[NUM_CS-1:0]  = cs_q;
        reg_rdata           = '0;
        case (rw_address[4:2])
            REG_CPOL:   reg_rdata = {31'd0, cpol_q};
            REG_CPHA:   reg_rdata = {31'd0, cpha_q};
            REG_CS:     reg_rdata = cs_ext;
            REG_DIV:    reg_rdata = {24'd0, div_q};
            REG_RDATA:  reg_rdata = {24'd0, rdata_q};
            REG_STATUS: reg_rdata = {31'd0, busy};
            default:    reg_rdata = '0;
        endcase
    end

    // Bus responses and configuration writes; config is frozen while busy, CS never is
    always_comb begin
        read_response_d  = read_request;
        read_data_d      = read_request ? reg_rdata : 32'd0;
        write_response_d = write_request;
        cpol_d           = cpol_q;
        cpha_d           = cpha_q;
        cs_d             = cs_q;
        div_d            = div_q;
        if (wr_en) begin
            case (rw_address[4:2])
                REG_CPOL: if (!busy) cpol_d = write_data[0];
                REG_CPHA: if (!busy) cpha_d = write_data[0];
                REG_CS:   cs_d = write_data[NUM_CS-1:0];
                REG_DIV:  if (!busy) div_d = write_data[7:0];
                default:  ;
            endcase
        end
    end

    // Transfer FSM: next state, half-period/bit counters, shift registers, sclk/pico
    always_comb begin
        state_d   = state_q;
        hp_cnt_d  = hp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        sclk_d    = sclk_q;
        pico_d    = pico_q;
        case (state_q)
            IDLE: begin
                sclk_d = cpol_d;
                if (wr_en && rw_address[4:2] == REG_WDATA) begin
                    state_d   = LEAD;
                    hp_cnt_d  = 8'd0;
                    bit_cnt_d = 4'd8;
                    if (!cpha_q) begin
                        pico_d = write_data[7];
                        tx_d   = {write_data[6:0], 1'b0};
                    end else begin
                        tx_d   = write_data[7:0];
                    end
                end
            end
            LEAD: begin
                if (half_done) begin
                    state_d  = TRAIL;
                    hp_cnt_d = 8'd0;
                    sclk_d   = ~cpol_q;
                    if (!cpha_q) begin
                        rx_d = {rx_q[6:0], poci_s2_q};
                    end else begin
                        pico_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
            TRAIL: begin
                if (half_done) begin
                    hp_cnt_d  = 8'd0;
                    sclk_d    = cpol_q;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    if (cpha_q) begin
                        rx_d = {rx_q[6:0], poci_s2_q};
                    end else if (bit_cnt_q != 4'd1) begin
                        pico_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (bit_cnt_q == 4'd1) begin
                        state_d = IDLE;
                        rdata_d = rx_d;
                    end else begin
                        state_d = LEAD;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any transfer in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            cpol_q           <= 1'b0;
            cpha_q           <= 1'b0;
            cs_q             <= '1;
            div_q            <= 8'd0;
            rdata_q          <= 8'd0;
            hp_cnt_q         <= 8'd0;
            bit_cnt_q        <= 4'd0;
            tx_q             <= 8'd0;
            rx_q             <= 8'd0;
            sclk_q           <= 1'b0;
            pico_q           <= 1'b0;
            poci_s1_q        <= 1'b0;
            poci_s2_q        <= 1'b0;
            read_response_q  <= 1'b0;
            read_data_q      <= 32'd0;
            write_response_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cpol_q           <= cpol_d;
            cpha_q           <= cpha_d;
            cs_q             <= cs_d;
            div_q            <= div_d;
            rdata_q          <= rdata_d;
            hp_cnt_q         <= hp_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            tx_q             <= tx_d;
            rx_q             <= rx_d;
            sclk_q           <= sclk_d;
            pico_q           <= pico_d;
            poci_s1_q        <= poci_s1_d;
            poci_s2_q        <= poci_s2_d;
            read_response_q  <= read_response_d;
            read_data_q      <= read_data_d;
            write_response_q <= write_response_d;
        end
    end
endmodule

// File: tb/tb_rvsteel_spi.sv
// tb/tb_rvsteel_spi.sv - scoreboard bench for rvsteel_spi with an SPI peer model
module tb_rvsteel_spi;
    localparam int NUM_CS = 2;
    localparam logic [4:0] A_CPOL = 5'h00, A_CPHA = 5'h04, A_CS = 5'h08, A_DIV = 5'h0C;
    localparam logic [4:0] A_WDATA = 5'h10, A_RDATA = 5'h14, A_STATUS = 5'h18, A_NONE = 5'h1C;

    logic              clock;
    logic              reset;
    logic [4:0]        rw_address;
    logic [31:0]       read_data;
    logic              read_request;
    logic              read_response;
    logic [31:0]       write_data;
    logic [3:0]        write_strobe;
    logic              write_request;
    logic              write_response;
    logic              sclk;
    logic              pico;
    logic              poci;
    logic [NUM_CS-1:0] cs;

    logic loopback;
    logic peer_out;
    assign poci = loopback ? pico : peer_out;

    rvsteel_spi #(.NUM_CS(NUM_CS)) dut (
        .clock(clock), .reset(reset), .rw_address(rw_address),
        .read_data(read_data), .read_request(read_request), .read_response(read_response),
        .write_data(write_data), .write_strobe(write_strobe), .write_request(write_request),
        .write_response(write_response), .sclk(sclk), .pico(pico), .poci(poci), .cs(cs)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t       rd_q[$];
    int         wr_q[$];
    int         total;
    int         bad;
    int         cyc;
    int         arm_tog;
    logic       m_cpol, m_cpha;
    logic [7:0] peer_init, peer_rx;
    int         lead_cnt;
    int         t0, tend;
    logic       x_cpol;
    logic [7:0] x_tx, x_rd;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Model of STATUS.busy for a read whose request edge is cycle e
    function automatic logic [31:0] busy_exp(input int e);
        return (e > t0 && e <= tend) ? 32'd1 : 32'd0;
    endfunction

    task automatic cycle_counter();
        forever begin
            @(posedge clock);
            cyc++;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (read_response) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    check(e.nm, read_data, e.data);
                    check({e.nm, "_latency"}, cyc, e.cyc);
                end
            end else begin
                check("rd_data_idle", read_data, 32'd0);
                if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                    e = rd_q.pop_front();
                    check({e.nm, "_missing"}, 32'd0, 32'd1);
                end
            end
            if (write_response) begin
                if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else check("wr_latency", cyc, wr_q.pop_front());
            end else if (wr_q.size() > 0 && wr_q[0] < cyc) begin
                void'(wr_q.pop_front());
                check("wr_missing", 32'd0, 32'd1);
            end
        end
    endtask

    // SPI peer: samples pico and drives its own byte MSB first per CPOL/CPHA
    task automatic peer_model();
        logic       prev;
        int         last_arm;
        logic [7:0] ptx;
        prev = 1'b0;
        last_arm = 0;
        ptx = 8'd0;
        forever begin
            @(negedge clock);
            if (arm_tog != last_arm) begin
                last_arm = arm_tog;
                ptx      = peer_init;
                peer_rx  = 8'd0;
                lead_cnt = 0;
                if (!m_cpha) begin
                    peer_out = ptx[7];
                    ptx      = {ptx[6:0], 1'b0};
                end
            end else if (sclk !== prev) begin
                if (sclk !== m_cpol) begin
                    lead_cnt++;
                    if (!m_cpha) peer_rx = {peer_rx[6:0], pico};
                    else begin
                        peer_out = ptx[7];
                        ptx      = {ptx[6:0], 1'b0};
                    end
                end else begin
                    if (m_cpha) peer_rx = {peer_rx[6:0], pico};
                    else begin
                        peer_out = ptx[7];
                        ptx      = {ptx[6:0], 1'b0};
                    end
                end
            end
            prev = sclk;
        end
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        rw_address    = addr;
        write_data    = data;
        write_strobe  = strb;
        write_request = 1'b1;
        @(posedge clock);
        #1;
        wr_q.push_back(cyc);
        write_request = 1'b0;
        write_strobe  = 4'd0;
    endtask

    task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string nm);
        exp_t e;
        rw_address   = addr;
        read_request = 1'b1;
        @(posedge clock);
        #1;
        e.data = exp;
        e.cyc  = cyc;
        e.nm   = nm;
        rd_q.push_back(e);
        read_request = 1'b0;
    endtask

    task automatic start_xfer(input logic cp, input logic cph, input logic [7:0] dv,
                              input logic [7:0] tx, input logic [7:0] pb, input logic lb);
        bus_write(A_CPOL, {31'd0, cp}, 4'b0001);
        bus_write(A_CPHA, {31'd0, cph}, 4'b0001);
        bus_write(A_DIV, {24'd0, dv}, 4'b0001);
        check("sclk_idle_level", sclk, cp);
        m_cpol    = cp;
        m_cpha    = cph;
        peer_init = pb;
        loopback  = lb;
        x_cpol    = cp;
        x_tx      = tx;
        x_rd      = lb ? tx : pb;
        arm_tog++;
        bus_write(A_WDATA, {24'd0, tx}, 4'b0001);
        t0   = cyc;
        tend = t0 + 16 * (int'(dv) + 1);
        if (!cph) check("pico_bit7_first", pico, tx[7]);
        bus_read(A_STATUS, busy_exp(cyc + 1), "status_busy_start");
    endtask

    task automatic finish_xfer();
        while (cyc < tend - 1) begin
            @(posedge clock);
            #1;
        end
        bus_read(A_STATUS, busy_exp(cyc + 1), "status_busy_last");
        bus_read(A_STATUS, busy_exp(cyc + 1), "status_busy_clear");
        check("sclk_end_level", sclk, x_cpol);
        check("sclk_pulses", lead_cnt, 8);
        check("peer_rx_byte", peer_rx, x_tx);
        bus_read(A_RDATA, {24'd0, x_rd}, "rdata");
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; arm_tog = 0;
        t0 = -100; tend = -100;
        m_cpol = 0; m_cpha = 0; peer_init = 0; peer_rx = 0; lead_cnt = 0; peer_out = 0;
        x_cpol = 0; x_tx = 0; x_rd = 0;
        loopback = 1'b1;
        reset = 1'b0;
        rw_address = 5'd0; read_request = 0; write_request = 0;
        write_data = 32'd0; write_strobe = 4'd0;
        fork
            cycle_counter();
            monitor();
            peer_model();
            begin
                repeat (60000) @(posedge clock);
                $display("FAIL watchdog: got cycle %0d expected completion", cyc);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_sclk", sclk, 0);
        check("rst_pico", pico, 0);
        check("rst_cs", 32'(cs), 32'h3);
        check("rst_rresp", read_response, 0);
        check("rst_wresp", write_response, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        bus_read(A_CPOL, 32'd0, "rst_cpol");
        bus_read(A_CPHA, 32'd0, "rst_cpha");
        bus_read(A_CS, 32'h3, "rst_cs_reg");
        bus_read(A_DIV, 32'd0, "rst_div");
        bus_read(A_RDATA, 32'd0, "rst_rdata");
        bus_read(A_STATUS, 32'd0, "rst_status");
        bus_read(A_WDATA, 32'd0, "rd_wdata_zero");
        bus_read(A_NONE, 32'd0, "rd_1c_zero");

        // Mode 0 loopback
        start_xfer(1'b0, 1'b0, 8'd3, 8'hA5, 8'h00, 1'b1);
        finish_xfer();

        // Chip select writes with and without strobe
        bus_write(A_CS, 32'hFFFF_FFFE, 4'b0001);
        check("cs_write", 32'(cs), 32'h2);
        bus_write(A_CS, 32'hFFFF_FFFF, 4'b0000);
        check("cs_nostrobe", 32'(cs), 32'h2);
        bus_read(A_CS, 32'h2, "cs_reg");

        // Mode 3 with peer driving 0x3C
        start_xfer(1'b1, 1'b1, 8'd3, 8'h96, 8'h3C, 1'b0);
        finish_xfer();

        // Config lock while busy
        start_xfer(1'b0, 1'b0, 8'd3, 8'h22, 8'h00, 1'b1);
        repeat (8) @(posedge clock);
        #1;
        bus_write(A_WDATA, 32'h11, 4'b0001);
        bus_write(A_CPOL, 32'h1, 4'b0001);
        bus_write(A_DIV, 32'h7, 4'b0001);
        finish_xfer();
        bus_read(A_CPOL, 32'd0, "cpol_locked");
        bus_read(A_DIV, 32'd3, "div_locked");

        // Randomized transfers against the peer model
        for (int i = 0; i < 8; i++) begin
            logic [7:0] dv;
            int         w;
            dv = 8'($urandom_range(2, 6));
            start_xfer(1'($urandom), 1'($urandom), dv, 8'($urandom), 8'($urandom), 1'b0);
            w = $urandom_range(0, 16 * (int'(dv) + 1) - 6);
            repeat (w) @(posedge clock);
            #1;
            bus_read(A_STATUS, busy_exp(cyc + 1), "status_mid");
            finish_xfer();
        end

        // Reset in the middle of a transfer
        start_xfer(1'b0, 1'b0, 8'd3, 8'hFF, 8'h00, 1'b1);
        while (cyc < t0 + 20) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        check("abort_sclk", sclk, 0);
        check("abort_cs", 32'(cs), 32'h3);
        check("abort_pico", pico, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        t0 = -100;
        tend = -100;
        @(posedge clock);
        #1;
        bus_read(A_STATUS, 32'd0, "abort_status");
        bus_read(A_RDATA, 32'd0, "abort_rdata");
        start_xfer(1'b0, 1'b1, 8'd2, 8'h5A, 8'h00, 1'b1);
        finish_xfer();

        repeat (4) @(posedge clock);
        #1;
        check("scoreboard_rd_empty", rd_q.size(), 0);
        check("scoreboard_wr_empty", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
